// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch slice: word type, fetch FSM states, watchdog width.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HIT,
    HALTED
  } fetch_state_t;

  localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/fetch_perf_counters.sv
// Free-running fetch performance counters: captured instructions and stall cycles.
// Both counters wrap silently at 2^32.
module fetch_perf_counters
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  cap_en,
  input  logic  stall_en,
  output word_t fetch_count,
  output word_t stall_count
);

  // Count one capture per REQ->HIT edge and one stall per qualifying cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (cap_en)   fetch_count <= fetch_count + 32'd1;
      if (stall_en) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch requester: issues reads for the current PC, absorbs
// memory wait states, registers the returned word and strobes ihit.
// Includes a sticky wait-state watchdog and performance counters.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
)(
  input  logic  CLK,
  input  logic  RST,
  input  word_t PCAddr,
  input  logic  Halt,
  input  logic  dmem_busy,
  input  logic  iwait,
  input  word_t iload,
  output logic  iREN,
  output word_t iaddr,
  output logic  ihit,
  output word_t instr,
  output logic  fetch_err,
  output word_t fetch_count,
  output word_t stall_count
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  fetch_state_t          state, state_n;
  word_t                 addr_q;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_nxt;
  logic                  req_enter;
  logic                  wait_cyc;
  logic                  cap_en;
  logic                  stall_en;

  // Outputs decode directly from state so reset drops iREN without waiting for an edge.
  assign iREN  = (state == REQ);
  assign ihit  = (state == HIT);
  assign iaddr = addr_q;

  assign wait_cyc = (state == REQ) && iwait;
  assign cap_en   = (state == REQ) && !iwait;
  assign stall_en = wait_cyc || ((state == IDLE) && dmem_busy && !Halt);
  assign wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

  // Next-state decode; Halt is only honoured outside REQ so an issued read always completes.
  always_comb begin
    state_n   = state;
    req_enter = 1'b0;
    unique case (state)
      IDLE: begin
        if (Halt) begin
          state_n = HALTED;
        end else if (!dmem_busy) begin
          state_n   = REQ;
          req_enter = 1'b1;
        end
      end
      REQ: begin
        if (!iwait) state_n = HIT;
      end
      HIT: begin
        if (Halt) begin
          state_n = HALTED;
        end else if (!dmem_busy) begin
          state_n   = REQ;
          req_enter = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      HALTED: state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end

  // State, request address and captured instruction registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      addr_q <= '0;
      instr  <= '0;
    end else begin
      state <= state_n;
      if (req_enter) addr_q <= PCAddr;
      if (cap_en)    instr  <= iload;
    end
  end

  // Per-request wait counter (saturating) and sticky watchdog flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (req_enter) begin
        wait_cnt <= '0;
      end else if (wait_cyc) begin
        wait_cnt <= wait_nxt;
        if (wait_nxt == MAX_WAIT_C) fetch_err <= 1'b1;
      end
    end
  end

  fetch_perf_counters u_perf (
    .CLK         (CLK),
    .RST         (RST),
    .cap_en      (cap_en),
    .stall_en    (stall_en),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

endmodule
